// File: rtl/slot_pkg.sv
// Shared slot-machine types and default credit constants.
// Used by the credit ledger, the coin display and the game controller.
// No logic lives here; there is no latency and no backpressure.
package slot_pkg;

    // Round state of the credit ledger.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    // One decimal digit and a three-digit {hundreds,tens,units} credit value.
    typedef logic [3:0]  bcd_digit_t;
    typedef logic [11:0] credit_t;

    // Default game economics, all in BCD.
    localparam credit_t BET_BCD    = 12'h015;
    localparam credit_t WIN_BCD    = 12'h100;
    localparam credit_t MAX_BCD    = 12'h999;

    // Coin values, in BCD.
    localparam credit_t COIN5_BCD  = 12'h005;
    localparam credit_t COIN10_BCD = 12'h010;

endpackage

// File: rtl/bcd3_addsub.sv
// Three-digit BCD adder/subtractor with per-digit decimal carry/borrow correction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the operands in the same cycle.
//
// Ports:
//   a, b   : BCD operands {hundreds,tens,units}
//   sub    : 0 = a + b, 1 = a - b
//   result : BCD result
//   carry  : decimal carry out of the hundreds digit (add) or borrow (sub)
module bcd3_addsub
    import slot_pkg::*;
(
    input  credit_t a,
    input  credit_t b,
    input  logic    sub,
    output credit_t result,
    output logic    carry
);

    always_comb begin
        logic       c;
        logic [4:0] s;
        bcd_digit_t da;
        bcd_digit_t db;

        c      = 1'b0;
        s      = '0;
        da     = '0;
        db     = '0;
        result = '0;
        for (int i = 0; i < 3; i++) begin
            da = a[i*4 +: 4];
            db = b[i*4 +: 4];
            if (!sub) begin
                // Binary digit sum above 9 is pushed past 15 by adding 6,
                // which leaves the correct decimal digit in the low nibble.
                s = {1'b0, da} + {1'b0, db} + {4'b0000, c};
                if (s > 5'd9) begin
                    s = s + 5'd6;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
            end else begin
                // A negative digit difference (bit 4 set) is corrected by
                // subtracting 6, equivalent to adding 10 modulo 16.
                s = {1'b0, da} - {1'b0, db} - {4'b0000, c};
                if (s[4]) begin
                    s = s - 5'd6;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
            end
            result[i*4 +: 4] = s[3:0];
        end
        carry = c;
    end

endmodule

// File: rtl/credit_ledger.sv
// Credit bookkeeping for the slot game: coins in, bets out, jackpots in, BCD credit display.
// Latency: every response and credit update is registered, visible the cycle after the sampling edge.
// Backpressure: none upstream; coins queue in small pending counters, overflow is dropped and flagged.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   coin5, coin10      : one-cycle coin events (5 and 10 units)
//   bet_req            : start-of-round request, answered by bet_ack or bet_nak
//   round_done/win     : end of round, win qualifies a jackpot
//   refund_req         : cash-out request (only acted on when CREDIT_REFUND_EN is defined)
//   bet_ack, bet_nak   : one-cycle responses
//   playing            : high from an accepted bet until round_done
//   credit             : current credit, BCD {hundreds,tens,units}
//   coin_lost          : one-cycle pulse, a coin event was dropped
//   refund_done        : one-cycle pulse, refund executed (tied 0 without CREDIT_REFUND_EN)
//
// Build option: define CREDIT_REFUND_EN to add the cash-out path.
module credit_ledger
    import slot_pkg::*;
#(
    parameter credit_t BET_BCD = slot_pkg::BET_BCD,
    parameter credit_t WIN_BCD = slot_pkg::WIN_BCD,
    parameter credit_t MAX_BCD = slot_pkg::MAX_BCD,
    parameter int      PEND_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin5,
    input  logic        coin10,
    input  logic        bet_req,
    input  logic        round_done,
    input  logic        round_win,
    input  logic        refund_req,
    output logic        bet_ack,
    output logic        bet_nak,
    output logic        playing,
    output logic [11:0] credit,
    output logic        coin_lost,
    output logic        refund_done
);

    localparam logic [PEND_W-1:0] PEND_FULL = {PEND_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [PEND_W-1:0] pend5;
    logic [PEND_W-1:0] pend10;
    logic [PEND_W-1:0] pend5_nxt;
    logic [PEND_W-1:0] pend10_nxt;

    logic    op_bet;
    logic    op_win;
    logic    op_c10;
    logic    op_c5;
    logic    op_arith;
    logic    blocked;
    logic    take5;
    logic    take10;
    logic    lost;
    credit_t operand;
    logic    sub;
    credit_t sum;
    logic    sum_carry;
    credit_t sum_sat;
    credit_t credit_nxt;

`ifdef CREDIT_REFUND_EN
    logic op_refund;
    // A refund only wins the edge when no bet is being deducted.
    assign op_refund = (state == IDLE) && refund_req && !op_bet;
    assign blocked   = op_bet || op_win || op_refund;
`else
    logic unused_refund_req;
    assign unused_refund_req = refund_req;
    assign blocked           = op_bet || op_win;
`endif

    // Operation selection in priority order; at most one reaches the adder.
    assign op_bet   = (state == IDLE) && bet_req && (credit >= BET_BCD);
    assign op_win   = (state == PLAYING) && round_done && round_win;
    assign op_c10   = (pend10 != '0) && !blocked;
    assign op_c5    = (pend5 != '0) && !blocked && !op_c10;
    assign op_arith = op_bet || op_win || op_c10 || op_c5;

    always_comb begin
        operand = COIN5_BCD;
        sub     = 1'b0;
        if (op_bet) begin
            operand = BET_BCD;
            sub     = 1'b1;
        end else if (op_win) begin
            operand = WIN_BCD;
        end else if (op_c10) begin
            operand = COIN10_BCD;
        end
    end

    bcd3_addsub u_addsub (
        .a      (credit),
        .b      (operand),
        .sub    (sub),
        .result (sum),
        .carry  (sum_carry)
    );

    // Subtraction cannot underflow because a bet is only taken when credit covers
    // it. BCD digit order matches numeric order, so a plain compare is exact.
    assign sum_sat = (!sub && (sum_carry || (sum > MAX_BCD))) ? MAX_BCD : sum;

    always_comb begin
        credit_nxt = credit;
`ifdef CREDIT_REFUND_EN
        if (op_refund) begin
            credit_nxt = '0;
        end else
`endif
        if (op_arith) begin
            credit_nxt = sum_sat;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_bet) state_nxt = PLAYING;
            PLAYING: if (round_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A full counter still accepts a coin on the edge it drains one, so only
    // arrivals into a full counter that is not being applied are dropped.
    assign take5      = coin5  && ((pend5  != PEND_FULL) || op_c5);
    assign take10     = coin10 && ((pend10 != PEND_FULL) || op_c10);
    assign pend5_nxt  = pend5  + PEND_W'(take5)  - PEND_W'(op_c5);
    assign pend10_nxt = pend10 + PEND_W'(take10) - PEND_W'(op_c10);
    assign lost       = (coin5 && !take5) || (coin10 && !take10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            credit    <= '0;
            pend5     <= '0;
            pend10    <= '0;
            bet_ack   <= 1'b0;
            bet_nak   <= 1'b0;
            playing   <= 1'b0;
            coin_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            credit    <= credit_nxt;
            pend5     <= pend5_nxt;
            pend10    <= pend10_nxt;
            bet_ack   <= op_bet;
            bet_nak   <= bet_req && !op_bet;
            playing   <= (state_nxt == PLAYING);
            coin_lost <= lost;
        end
    end

`ifdef CREDIT_REFUND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refund_done <= 1'b0;
        end else begin
            refund_done <= op_refund;
        end
    end
`else
    assign refund_done = 1'b0;
`endif

endmodule

// File: tb/tb_credit_ledger.sv
// Directed testbench for credit_ledger: vector table plus hand-written corner sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// With CREDIT_REFUND_EN defined the cash-out sequence expects a refund, otherwise none.
module tb_credit_ledger;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin5;
    logic        coin10;
    logic        bet_req;
    logic        round_done;
    logic        round_win;
    logic        refund_req;
    logic        bet_ack;
    logic        bet_nak;
    logic        playing;
    logic [11:0] credit;
    logic        coin_lost;
    logic        refund_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    credit_ledger dut (
        .clk         (clk),
        .rst         (rst),
        .coin5       (coin5),
        .coin10      (coin10),
        .bet_req     (bet_req),
        .round_done  (round_done),
        .round_win   (round_win),
        .refund_req  (refund_req),
        .bet_ack     (bet_ack),
        .bet_nak     (bet_nak),
        .playing     (playing),
        .credit      (credit),
        .coin_lost   (coin_lost),
        .refund_done (refund_done)
    );

    typedef struct {
        logic        c5;
        logic        c10;
        logic        bet;
        logic        done;
        logic        win;
        logic [11:0] e_credit;
        logic        e_ack;
        logic        e_nak;
        logic        e_play;
        logic        e_lost;
    } vec_t;

    vec_t vecs[29];

    task automatic check(input string name, input int idx, input logic [11:0] act,
                         input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [11:0] e_credit,
                             input logic e_ack, input logic e_nak, input logic e_play,
                             input logic e_lost);
        check({tag, ".credit"},    idx, credit,              e_credit);
        check({tag, ".bet_ack"},   idx, {11'd0, bet_ack},    {11'd0, e_ack});
        check({tag, ".bet_nak"},   idx, {11'd0, bet_nak},    {11'd0, e_nak});
        check({tag, ".playing"},   idx, {11'd0, playing},    {11'd0, e_play});
        check({tag, ".coin_lost"}, idx, {11'd0, coin_lost},  {11'd0, e_lost});
    endtask

    // Apply one cycle of inputs and land 1 ns after the edge that sampled them.
    task automatic drive(input logic c5, input logic c10, input logic bet,
                         input logic done, input logic win, input logic refund);
        coin5      = c5;
        coin10     = c10;
        bet_req    = bet;
        round_done = done;
        round_win  = win;
        refund_req = refund;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    initial begin
        int exp_credit;

        //           c5   c10  bet  done win   credit   ack  nak  play lost
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 12'h000, 1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 12'h010, 1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h015, 1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 12'h000, 1'b1,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h000, 1'b0,1'b0,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 12'h000, 1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 12'h000, 1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 12'h005, 1'b0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h010, 1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 12'h010, 1'b0,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h010, 1'b0,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 12'h010, 1'b0,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h015, 1'b0,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 12'h000, 1'b1,1'b0,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h005, 1'b0,1'b0,1'b1,1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 12'h105, 1'b0,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 12'h105, 1'b0,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 12'h090, 1'b1,1'b0,1'b1,1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 12'h190, 1'b0,1'b0,1'b0,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 12'h175, 1'b1,1'b0,1'b1,1'b1};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h180, 1'b0,1'b0,1'b1,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 12'h185, 1'b0,1'b1,1'b1,1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 12'h190, 1'b0,1'b0,1'b1,1'b0};
        vecs[23] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 12'h190, 1'b0,1'b1,1'b0,1'b0};
        vecs[24] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 12'h190, 1'b0,1'b0,1'b0,1'b0};
        vecs[25] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h200, 1'b0,1'b0,1'b0,1'b0};
        vecs[26] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 12'h205, 1'b0,1'b0,1'b0,1'b0};
        vecs[27] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 12'h190, 1'b1,1'b0,1'b1,1'b0};
        vecs[28] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 12'h290, 1'b0,1'b0,1'b0,1'b0};

        // Reset state.
        rst        = 1'b1;
        coin5      = 1'b0;
        coin10     = 1'b0;
        bet_req    = 1'b0;
        round_done = 1'b0;
        round_win  = 1'b0;
        refund_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.refund_done", 0, {11'd0, refund_done}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Main vector table; state carries over from one vector to the next.
        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].c5, vecs[i].c10, vecs[i].bet, vecs[i].done, vecs[i].win, 1'b0);
            check_all("vec", i, vecs[i].e_credit, vecs[i].e_ack, vecs[i].e_nak,
                      vecs[i].e_play, vecs[i].e_lost);
            check("vec.refund_done", i, {11'd0, refund_done}, 12'h000);
        end

        // Climb to 965 with winning rounds and coins, then saturate a jackpot.
        exp_credit = 290;
        for (int r = 0; r < 7; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_credit -= 15;
            check_all("climb_bet", r, to_bcd(exp_credit), 1'b1, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            exp_credit += 100;
            check("climb_win.credit", r, credit, to_bcd(exp_credit));
        end
        for (int m = 0; m < 8; m++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_credit += 10;
            check("climb_coin.credit", m, credit, to_bcd(exp_credit));
        end
        check("climb_total", 0, credit, 12'h965);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("sat_bet", 0, 12'h950, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("sat_win", 0, 12'h999, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("sat_coin", 0, 12'h999, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a round with 085 of credit left.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int m = 0; m < 10; m++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("pre_rst.credit", 0, credit, 12'h100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("pre_rst_bet", 0, 12'h085, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Build 045 and issue a cash-out request in IDLE.
        for (int m = 0; m < 4; m++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_refund.credit", 0, credit, 12'h045);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CREDIT_REFUND_EN
        check("refund.credit", 0, credit, 12'h000);
        check("refund.refund_done", 0, {11'd0, refund_done}, 12'h001);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_refund.credit", 0, credit, 12'h000);
        check("post_refund.refund_done", 0, {11'd0, refund_done}, 12'h000);
`else
        check("refund.credit", 0, credit, 12'h045);
        check("refund.refund_done", 0, {11'd0, refund_done}, 12'h000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_refund.credit", 0, credit, 12'h045);
        check("post_refund.refund_done", 0, {11'd0, refund_done}, 12'h000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
